// File: rtl/sensor_conditioner.sv
// Debounces entry/exit sensors and turns qualified edges into single event pulses with a slot index.
// Latency DEBOUNCE_CYCLES+3 from raw edge to pulse; no backpressure, a colliding exit is deferred one cycle.

module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sens,
    output logic strobe
);
    typedef enum logic [1:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               strobe_q, strobe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sens) begin
                    state_d = QUAL_ON;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_ON: begin
                if (!sens) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d  = ACTIVE;
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ACTIVE: begin
                if (!sens) begin
                    state_d = QUAL_OFF;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_OFF: begin
                // Level bouncing back high just resumes ACTIVE; only a full release re-arms
                if (sens) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign strobe = strobe_q;
endmodule

module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_raw,
    input  logic       exit_raw,
    input  logic [1:0] switch_raw,
    input  logic       full,
    output logic       entry_event,
    output logic       exit_event,
    output logic [1:0] slot_sel,
    output logic       entry_rejected
);
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       entry_stb, exit_stb;
    logic [1:0] sw_sync;

    logic       entry_event_q, entry_event_d;
    logic       exit_event_q, exit_event_d;
    logic       entry_rejected_q, entry_rejected_d;
    logic [1:0] slot_sel_q, slot_sel_d;
    logic       pend_exit_q, pend_exit_d;
    logic [1:0] pend_exit_slot_q, pend_exit_slot_d;
    logic       pend_ent_q, pend_ent_d;
    logic [1:0] pend_ent_slot_q, pend_ent_slot_d;
    logic       pend_ent_full_q, pend_ent_full_d;

    always_comb begin
        sync1_d = {switch_raw, exit_raw, entry_raw};
        sync2_d = sync1_q;
    end

    assign sw_sync = sync2_q[3:2];

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_entry_db (
        .clk    (clk),
        .rst    (rst),
        .sens   (sync2_q[0]),
        .strobe (entry_stb)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_exit_db (
        .clk    (clk),
        .rst    (rst),
        .sens   (sync2_q[1]),
        .strobe (exit_stb)
    );

    // Issue priority: pending exit, pending entry, new entry, new exit; the loser is parked with its samples
    always_comb begin
        entry_event_d    = 1'b0;
        exit_event_d     = 1'b0;
        entry_rejected_d = 1'b0;
        slot_sel_d       = slot_sel_q;
        pend_exit_d      = pend_exit_q;
        pend_exit_slot_d = pend_exit_slot_q;
        pend_ent_d       = pend_ent_q;
        pend_ent_slot_d  = pend_ent_slot_q;
        pend_ent_full_d  = pend_ent_full_q;

        if (pend_exit_q) begin
            exit_event_d = 1'b1;
            slot_sel_d   = pend_exit_slot_q;
            pend_exit_d  = 1'b0;
        end else if (pend_ent_q) begin
            entry_event_d    = !pend_ent_full_q;
            entry_rejected_d = pend_ent_full_q;
            slot_sel_d       = pend_ent_slot_q;
            pend_ent_d       = 1'b0;
        end else if (entry_stb) begin
            entry_event_d    = !full;
            entry_rejected_d = full;
            slot_sel_d       = sw_sync;
        end else if (exit_stb) begin
            exit_event_d = 1'b1;
            slot_sel_d   = sw_sync;
        end

        if (entry_stb && (pend_exit_q || pend_ent_q)) begin
            pend_ent_d      = 1'b1;
            pend_ent_slot_d = sw_sync;
            pend_ent_full_d = full;
        end
        if (exit_stb && (pend_exit_q || pend_ent_q || entry_stb)) begin
            pend_exit_d      = 1'b1;
            pend_exit_slot_d = sw_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q          <= '0;
            sync2_q          <= '0;
            entry_event_q    <= 1'b0;
            exit_event_q     <= 1'b0;
            entry_rejected_q <= 1'b0;
            slot_sel_q       <= 2'b00;
            pend_exit_q      <= 1'b0;
            pend_exit_slot_q <= 2'b00;
            pend_ent_q       <= 1'b0;
            pend_ent_slot_q  <= 2'b00;
            pend_ent_full_q  <= 1'b0;
        end else begin
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            entry_event_q    <= entry_event_d;
            exit_event_q     <= exit_event_d;
            entry_rejected_q <= entry_rejected_d;
            slot_sel_q       <= slot_sel_d;
            pend_exit_q      <= pend_exit_d;
            pend_exit_slot_q <= pend_exit_slot_d;
            pend_ent_q       <= pend_ent_d;
            pend_ent_slot_q  <= pend_ent_slot_d;
            pend_ent_full_q  <= pend_ent_full_d;
        end
    end

    assign entry_event    = entry_event_q;
    assign exit_event     = exit_event_q;
    assign entry_rejected = entry_rejected_q;
    assign slot_sel       = slot_sel_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4 (raw edge to pulse = 7 cycles).
module tb_sensor_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_raw = 1'b0;
    logic       exit_raw = 1'b0;
    logic [1:0] switch_raw = 2'b00;
    logic       full = 1'b0;
    logic       entry_event, exit_event, entry_rejected;
    logic [1:0] slot_sel;

    int errors = 0;
    int checks = 0;

    sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .entry_raw      (entry_raw),
        .exit_raw       (exit_raw),
        .switch_raw     (switch_raw),
        .full           (full),
        .entry_event    (entry_event),
        .exit_event     (exit_event),
        .slot_sel       (slot_sel),
        .entry_rejected (entry_rejected)
    );

    always #5 clk = ~clk;

    // Edge counter and output monitor; counters only grow, tests work on deltas
    int edge_cnt = 0;
    int n_ent = 0, n_exit = 0, n_rej = 0, n_overlap = 0;
    int ent_edge = -1, exit_edge = -1, rej_edge = -1;
    int ent_slot = -1, exit_slot = -1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (entry_event) begin
            n_ent    <= n_ent + 1;
            ent_edge <= edge_cnt;
            ent_slot <= int'(slot_sel);
        end
        if (exit_event) begin
            n_exit    <= n_exit + 1;
            exit_edge <= edge_cnt;
            exit_slot <= int'(slot_sel);
        end
        if (entry_rejected) begin
            n_rej    <= n_rej + 1;
            rej_edge <= edge_cnt;
        end
        if ((int'(entry_event) + int'(exit_event) + int'(entry_rejected)) > 1)
            n_overlap <= n_overlap + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int k0, k1, b_ent, b_exit, b_rej;

    task automatic snap();
        b_ent  = n_ent;
        b_exit = n_exit;
        b_rej  = n_rej;
    endtask

    initial begin
        // Reset state
        tick(3);
        check_val("rst_entry_event", int'(entry_event), 0);
        check_val("rst_exit_event", int'(exit_event), 0);
        check_val("rst_rejected", int'(entry_rejected), 0);
        check_val("rst_slot_sel", int'(slot_sel), 0);
        rst = 1'b0;
        tick(3);

        // Clean entry, slot 2
        switch_raw = 2'b10;
        tick(3);
        snap();
        k0 = edge_cnt;
        entry_raw = 1'b1;
        tick(12);
        check_val("t1_entry_count", n_ent - b_ent, 1);
        check_val("t1_entry_latency", ent_edge - (k0 + 1), 7);
        check_val("t1_slot", ent_slot, 2);
        check_val("t1_no_reject", n_rej - b_rej, 0);
        entry_raw = 1'b0;
        tick(20);

        // Short glitches filtered, then a held level qualifies once
        snap();
        for (int i = 0; i < 5; i++) begin
            entry_raw = 1'b1;
            tick(3);
            entry_raw = 1'b0;
            tick(2);
        end
        tick(10);
        check_val("t2_glitch_none", n_ent - b_ent, 0);
        k0 = edge_cnt;
        entry_raw = 1'b1;
        tick(30);
        check_val("t2_held_once", n_ent - b_ent, 1);
        check_val("t2_latency", ent_edge - (k0 + 1), 7);
        entry_raw = 1'b0;
        tick(20);

        // Simultaneous entry and exit; switch moves after the strobe sample
        switch_raw = 2'b01;
        tick(3);
        snap();
        k0 = edge_cnt;
        entry_raw = 1'b1;
        exit_raw  = 1'b1;
        tick(6);
        switch_raw = 2'b11;
        tick(8);
        check_val("t3_entry_count", n_ent - b_ent, 1);
        check_val("t3_exit_count", n_exit - b_exit, 1);
        check_val("t3_entry_latency", ent_edge - (k0 + 1), 7);
        check_val("t3_exit_latency", exit_edge - (k0 + 1), 8);
        check_val("t3_entry_slot", ent_slot, 1);
        check_val("t3_exit_slot", exit_slot, 1);
        entry_raw = 1'b0;
        exit_raw  = 1'b0;
        tick(20);

        // Lot full: entry rejected, exit still issued
        full = 1'b1;
        snap();
        k0 = edge_cnt;
        entry_raw = 1'b1;
        tick(12);
        check_val("t4_reject_count", n_rej - b_rej, 1);
        check_val("t4_reject_latency", rej_edge - (k0 + 1), 7);
        check_val("t4_no_entry", n_ent - b_ent, 0);
        k1 = edge_cnt;
        exit_raw = 1'b1;
        tick(12);
        check_val("t4_exit_count", n_exit - b_exit, 1);
        check_val("t4_exit_latency", exit_edge - (k1 + 1), 7);
        entry_raw = 1'b0;
        exit_raw  = 1'b0;
        full      = 1'b0;
        tick(20);

        // Reset mid-qualification, level still high after release
        snap();
        entry_raw = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(4);
        check_val("t5_none_in_reset", n_ent - b_ent, 0);
        rst = 1'b0;
        k1 = edge_cnt;
        tick(30);
        check_val("t5_one_after", n_ent - b_ent, 1);
        check_val("t5_latency", ent_edge - (k1 + 1), 7);
        entry_raw = 1'b0;
        tick(20);

        // Held high with short dropouts, then a long dropout and re-rise
        snap();
        entry_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(10);
            entry_raw = 1'b0;
            tick(2);
            entry_raw = 1'b1;
        end
        tick(10);
        check_val("t6_one_event", n_ent - b_ent, 1);
        entry_raw = 1'b0;
        tick(6);
        entry_raw = 1'b1;
        tick(12);
        check_val("t6_second_event", n_ent - b_ent, 2);
        entry_raw = 1'b0;
        tick(10);

        check_val("never_overlap", n_overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
